// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter_if
// Brief  : Writeback request, MD result and register-file port bundle.
// Rev    : 1.0
// ============================================================================
interface wb_arbiter_if #(
  parameter int N = 32
) ();

  logic         pipe_valid;
  logic [4:0]   pipe_rd;
  logic [N-1:0] pipe_data;

  logic         md_valid;
  logic [4:0]   md_rd;
  logic [N-1:0] md_data;
  logic         md_ready;
  logic         md_issue;
  logic [4:0]   md_issue_rd;

  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [N-1:0] rf_wdata;

  logic [31:0]  busy_vec;
  logic         pipe_stall;
  logic         waw_err;
  logic         proto_err;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output md_valid, md_rd, md_data, md_issue, md_issue_rd,
    input  md_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_vec, pipe_stall, waw_err, proto_err
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  md_valid, md_rd, md_data, md_issue, md_issue_rd,
    output md_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy_vec, pipe_stall, waw_err, proto_err
  );

endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter
// Brief  : Register-file writeback arbiter between the main pipeline and a
//          FIFO of multiply/divide results, with starvation-forced drain.
// Rev    : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int N            = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  wb_arbiter_if.slave bus
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = c_pw + 1;
  localparam int c_sw = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
  localparam logic [c_sw-1:0] c_limit = c_sw'(STARVE_LIMIT);

  // MD result FIFO storage
  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [N-1:0]    r_fifo_data [DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;

  logic [c_sw-1:0] r_starve;
  logic [c_sw-1:0] w_starve_next;
  logic            r_stall;

  logic [31:0]     r_busy;
  logic [31:0]     w_busy_next;

  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [N-1:0]    r_rf_wdata;
  logic            r_waw_err;
  logic            r_proto_err;

  logic            w_md_ready;
  logic            w_fifo_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_pipe_eff;
  logic [4:0]      w_head_rd;
  logic [N-1:0]    w_head_data;

  // Request decode and selection
  always_comb begin
    w_md_ready   = (r_count < c_depth);
    w_fifo_empty = (r_count == '0);
    w_push       = bus.md_valid && w_md_ready;
    w_pipe_eff   = bus.pipe_valid && (bus.pipe_rd != 5'd0) && !r_stall;
    w_pop        = !w_pipe_eff && !w_fifo_empty;
    w_head_rd    = r_fifo_rd[r_rptr];
    w_head_data  = r_fifo_data[r_rptr];
  end

  // Heads only become visible through the registered count, so a result
  // pushed this cycle cannot be selected until the next one.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.md_rd;
      r_fifo_data[r_wptr] <= bus.md_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_pw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_fifo_empty || w_pop) begin
      w_starve_next = '0;
    end else if (r_starve != c_limit) begin
      w_starve_next = r_starve + c_sw'(1);
    end
  end

  // The stall is a single-cycle pulse: the head pops during it, so the
  // counter restarts from zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      r_stall  <= (r_starve == c_limit) && !r_stall;
    end
  end

  // A new issue to the same register outranks retiring the older result.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop && (w_head_rd != 5'd0)) begin
      w_busy_next[w_head_rd] = 1'b0;
    end
    if (bus.md_issue) begin
      w_busy_next[bus.md_issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Register-file write port; address and data hold when nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_pipe_eff) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= bus.pipe_rd;
      r_rf_wdata <= bus.pipe_data;
    end else if (w_pop && (w_head_rd != 5'd0)) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head_rd;
      r_rf_wdata <= w_head_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waw_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_pipe_eff && r_busy[bus.pipe_rd]) begin
        r_waw_err <= 1'b1;
      end
      if (bus.pipe_valid && r_stall) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign bus.md_ready   = w_md_ready;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_waddr   = r_rf_waddr;
  assign bus.rf_wdata   = r_rf_wdata;
  assign bus.busy_vec   = r_busy;
  assign bus.pipe_stall = r_stall;
  assign bus.waw_err    = r_waw_err;
  assign bus.proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_arbiter
// Brief  : Directed bench; expected register-file writes are queued with the
//          cycle they must appear in and checked every cycle.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N(N)) bus ();

  wb_arbiter #(
    .N            (N),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int           cyc;
    logic [4:0]   addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc         = 0;
  int  vectors     = 0;
  int  miscompares = 0;
  int  c0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [N-1:0] d, input int c);
    wr_t e;
    int  pos;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    pos = 0;
    while (pos < exp_q.size() && exp_q[pos].cyc <= c) pos++;
    exp_q.insert(pos, e);
  endtask

  // Advance one edge, then compare the write port against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("rf_we", bus.rf_we, 1'b1);
      check("rf_waddr", bus.rf_waddr, e.addr);
      check("rf_wdata", bus.rf_wdata, e.data);
    end else begin
      check("rf_we_idle", bus.rf_we, 1'b0);
    end
  endtask

  task automatic idle();
    bus.pipe_valid  = 1'b0;
    bus.pipe_rd     = 5'd0;
    bus.pipe_data   = '0;
    bus.md_valid    = 1'b0;
    bus.md_rd       = 5'd0;
    bus.md_data     = '0;
    bus.md_issue    = 1'b0;
    bus.md_issue_rd = 5'd0;
  endtask

  task automatic pipe_wr(input logic [4:0] a, input logic [N-1:0] d);
    bus.pipe_valid = 1'b1;
    bus.pipe_rd    = a;
    bus.pipe_data  = d;
    if (a != 5'd0) expect_wr(a, d, cyc + 1);
  endtask

  task automatic md_push(input logic [4:0] a, input logic [N-1:0] d, input int lat);
    bus.md_valid = 1'b1;
    bus.md_rd    = a;
    bus.md_data  = d;
    if (a != 5'd0) expect_wr(a, d, cyc + lat);
  endtask

  task automatic check_reset_state();
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_waddr", bus.rf_waddr, 5'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy_vec", bus.busy_vec, 32'd0);
    check("rst_pipe_stall", bus.pipe_stall, 1'b0);
    check("rst_waw_err", bus.waw_err, 1'b0);
    check("rst_proto_err", bus.proto_err, 1'b0);
    check("rst_md_ready", bus.md_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    check_reset_state();
    tick();
    reset = 1'b0;
    tick();

    // Plain pipeline write, then a pipeline request to r0 that must not write
    pipe_wr(5'd5, 32'hA5A5_A5A5);
    tick();
    idle();
    pipe_wr(5'd0, 32'hDEAD_BEEF);
    tick();
    idle();

    // MD result appears two edges after the push and retires its busy bit
    bus.md_issue    = 1'b1;
    bus.md_issue_rd = 5'd7;
    tick();
    idle();
    check("busy_after_issue7", bus.busy_vec, 32'h0000_0080);
    md_push(5'd7, 32'h1234_5678, 2);
    tick();
    idle();
    check("busy_before_pop7", bus.busy_vec, 32'h0000_0080);
    check("md_ready_one_entry", bus.md_ready, 1'b1);
    tick();
    check("busy_after_pop7", bus.busy_vec, 32'h0000_0000);

    // Pipeline wins over a waiting FIFO head, which follows in the next free cycle
    md_push(5'd4, 32'h4444_0004, 3);
    tick();
    idle();
    pipe_wr(5'd3, 32'h3333_0003);
    tick();
    idle();
    tick();
    tick();

    // An r0 MD result drains silently
    md_push(5'd0, 32'h0000_0BAD, 2);
    tick();
    idle();
    tick();
    tick();
    check("md_ready_after_r0", bus.md_ready, 1'b1);

    // Write-after-write hazard flag
    check("waw_clear", bus.waw_err, 1'b0);
    bus.md_issue    = 1'b1;
    bus.md_issue_rd = 5'd9;
    tick();
    idle();
    check("busy_issue9", bus.busy_vec, 32'h0000_0200);
    pipe_wr(5'd9, 32'h9999_9999);
    tick();
    idle();
    check("waw_set", bus.waw_err, 1'b1);
    tick();
    check("waw_sticky", bus.waw_err, 1'b1);

    // Re-issue in the pop cycle keeps the busy bit; a second result clears it
    md_push(5'd9, 32'h9009_9009, 2);
    tick();
    idle();
    bus.md_issue    = 1'b1;
    bus.md_issue_rd = 5'd9;
    tick();
    idle();
    check("busy_set_wins", bus.busy_vec, 32'h0000_0200);
    md_push(5'd9, 32'h9119_9119, 2);
    tick();
    idle();
    tick();
    check("busy_clear9", bus.busy_vec, 32'h0000_0000);

    // Starvation: FIFO fills behind a continuous pipeline stream
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      bus.pipe_valid = 1'b1;
      bus.pipe_rd    = 5'd1;
      bus.pipe_data  = 32'h100 + i;
      if (i < 6) expect_wr(5'd1, 32'h100 + i, cyc + 1);
      if (i == 0) begin
        bus.md_valid = 1'b1;
        bus.md_rd    = 5'd10;
        bus.md_data  = 32'hA0A0_A0A0;
        expect_wr(5'd10, 32'hA0A0_A0A0, c0 + 7);
      end
      if (i == 1) begin
        bus.md_rd   = 5'd11;
        bus.md_data = 32'hB0B0_B0B0;
        expect_wr(5'd11, 32'hB0B0_B0B0, c0 + 8);
      end
      if (i == 2) begin
        bus.md_rd   = 5'd12;
        bus.md_data = 32'hC0C0_C0C0;
      end
      if (i == 4) bus.md_valid = 1'b0;
      tick();
      check("starve_md_ready", bus.md_ready, (i == 0) || (i == 6));
      check("starve_pipe_stall", bus.pipe_stall, i == 5);
      check("starve_proto_err", bus.proto_err, i == 6);
    end
    idle();
    tick();
    check("starve_drained", bus.md_ready, 1'b1);
    check("starve_busy", bus.busy_vec, 32'h0000_0000);

    // Reset with a full FIFO and pending busy bits
    bus.md_issue    = 1'b1;
    bus.md_issue_rd = 5'd7;
    pipe_wr(5'd2, 32'h2000_0000);
    tick();
    bus.md_issue_rd = 5'd10;
    md_push(5'd7, 32'h7777_7777, 100);
    pipe_wr(5'd2, 32'h2000_0001);
    tick();
    bus.md_issue = 1'b0;
    bus.md_rd    = 5'd10;
    bus.md_data  = 32'hAAAA_AAAA;
    pipe_wr(5'd2, 32'h2000_0002);
    tick();
    idle();
    check("pre_rst_md_ready", bus.md_ready, 1'b0);
    check("pre_rst_busy", bus.busy_vec, 32'h0000_0480);
    // The queued MD write must never arrive once reset discards it
    exp_q = {};
    #2;
    reset = 1'b1;
    #1;
    check_reset_state();
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_md_ready", bus.md_ready, 1'b1);
    check("post_rst_busy", bus.busy_vec, 32'h0000_0000);
    pipe_wr(5'd6, 32'h6666_0006);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N, default 32: data width of register-file write data.
REQ-002 Parameter DEPTH, default 2: entries in the multiply/divide (MD) result FIFO; power of two ≥2.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive unserved cycles before forced drain.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pipe_valid  in  1  main-pipeline writeback request this cycle; cannot be back-pressured.
REQ-007 pipe_rd  in  5  pipeline destination register.
REQ-008 pipe_data  in  N  pipeline writeback data.
REQ-009 md_valid  in  1  MD unit result valid.
REQ-010 md_rd  in  5  MD result destination register.
REQ-011 md_data  in  N  MD result data.
REQ-012 md_ready  out  1  FIFO can accept an MD result.
REQ-013 md_issue  in  1  MD operation issued this cycle.
REQ-014 md_issue_rd  in  5  destination of the issued MD operation.
REQ-015 rf_we  out  1  register-file write enable (registered).
REQ-016 rf_waddr  out  5  register-file write address (registered).
REQ-017 rf_wdata  out  N  register-file write data (registered).
REQ-018 busy_vec  out  32  bit r set = MD result for register r pending.
REQ-019 pipe_stall  out  1  registered; pipeline must present no writeback this cycle.
REQ-020 waw_err  out  1  sticky: pipeline wrote a register whose busy bit was set.
REQ-021 proto_err  out  1  sticky: pipe_valid asserted while pipe_stall high.

Function
REQ-022 md_ready SHALL equal (FIFO count < DEPTH), combinational from registered count only.
REQ-023 Push SHALL occur on md_valid && md_ready; md_valid while !md_ready SHALL be ignored (MD unit holds).
REQ-024 A pushed entry SHALL be eligible for selection no earlier than the cycle after push (no bypass); write appears on rf_* two edges after push at minimum.
REQ-025 Pipeline request is "effective" when pipe_valid && pipe_rd != 0 && !pipe_stall.
REQ-026 Selection per cycle: effective pipeline request wins; else FIFO head popped if non-empty; else no write.
REQ-027 Selected write SHALL load rf_we=1, rf_waddr, rf_wdata at next edge; no selection SHALL load rf_we=0 with address/data held.
REQ-028 FIFO entries with rd=0 SHALL be popped but produce rf_we=0.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-030 Starvation counter SHALL increment each cycle FIFO non-empty and not popped, clear on any pop or empty FIFO, saturate at STARVE_LIMIT.
REQ-031 When counter == STARVE_LIMIT, pipe_stall SHALL be 1 the next cycle, for exactly one cycle; counter clears as FIFO head pops in that cycle.
REQ-032 During pipe_stall, FIFO head SHALL be popped; pipe_valid=1 SHALL be dropped and set proto_err.
REQ-033 busy_vec[r] SHALL set on md_issue with md_issue_rd=r≠0; clear when FIFO entry for r is popped; simultaneous set and clear of same r: set wins.
REQ-034 busy_vec[0] SHALL always be 0.
REQ-035 Effective pipeline write to r with busy_vec[r]=1 SHALL set waw_err; write still performed.

Reset
REQ-036 reset high SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, pipe_stall=0, waw_err=0, proto_err=0, FIFO count/pointers=0, starvation counter=0; md_ready=1 follows.
REQ-037 Reset mid-operation SHALL discard all FIFO contents and pending busy bits; no write issued in the first cycle after release unless pipeline requests one.

Verification
REQ-038 Pipe write rd=5 data=0xA5A5A5A5, FIFO empty -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5.
REQ-039 md push rd=7 data=0x12345678 at t, pipe idle -> rf_we=1 rd=7 at t+2; busy_vec[7] cleared at same edge.
REQ-040 Two md pushes then continuous pipe writes to rd=1 -> md_ready=0 with count=2; pipe_stall=1 after 4 unserved cycles; FIFO head written during stall cycle.
REQ-041 Same-cycle pipe write rd=3 and FIFO non-empty -> pipe written, FIFO head written following free cycle, order preserved.
REQ-042 md_issue rd=9 then pipe write rd=9 -> waw_err=1 sticky; pipe_valid during pipe_stall -> proto_err=1, write dropped.
REQ-043 Assert reset with FIFO count=2, busy_vec=0x0000_0480 -> outputs zero, md_ready=1, no stale MD write after release.
